// File: rtl/display_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller.
// Each digit owns a slot of SCAN_DIV cycles. The first BLANK_CYCLES cycles of
// a slot drive everything off so the previous digit's pattern cannot ghost
// onto the next one. The remainder of the slot shows that digit's pattern.
// The pattern is latched once at the start of the show phase, so writes never
// tear a digit that is currently lit.
module display_scan_ctrl #(
    parameter int SCAN_DIV     = 2500,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       disp_en,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] control,
    output logic [7:0] value,
    output logic       frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  slot_count;
    logic [CW-1:0]  slot_count_next;
    logic [2:0]     digit;
    logic [2:0]     digit_next;
    logic           slot_wrap;
    logic           wr_accept;
    logic [7:0]     control_next;
    logic [7:0]     value_next;
    logic           frame_done_next;
    logic [7:0]     pattern_buf [8];

    // A write is taken only when both sides agree on the same edge.
    assign wr_accept = wr_valid && wr_ready;

    // Pattern buffer: every digit powers up showing "0", one entry per write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                pattern_buf[i] <= 8'hC0;
            end
        end else if (wr_accept) begin
            pattern_buf[wr_addr] <= wr_data;
        end
    end

    // Ready drops for exactly one cycle after each accepted write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ready <= 1'b0;
        end else begin
            wr_ready <= !wr_accept;
        end
    end

    // Next-state and output decode; outputs are computed from the values the
    // counter and digit will hold after this edge so they can be registered.
    always_comb begin
        slot_wrap       = 1'b0;
        slot_count_next = slot_count;
        digit_next      = digit;
        state_next      = state;
        control_next    = 8'hFF;
        value_next      = value;
        frame_done_next = 1'b0;

        slot_wrap = (slot_count == SLOT_LAST);
        if (slot_wrap) begin
            slot_count_next = '0;
            digit_next      = digit + 3'd1;
        end else begin
            slot_count_next = slot_count + CW'(1);
        end
        frame_done_next = slot_wrap && (digit == 3'd7);

        state_next = (slot_count_next < BLANK_END) ? BLANK : SHOW;

        case (state_next)
            BLANK: begin
                value_next = 8'hFF;
            end
            SHOW: begin
                if (state == BLANK) begin
                    value_next = pattern_buf[digit_next];
                end
                if (disp_en) begin
                    control_next = ~(8'h01 << digit_next);
                end
            end
            default: begin
                value_next = 8'hFF;
            end
        endcase
    end

    // State, slot position and registered display outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= BLANK;
            slot_count <= '0;
            digit      <= 3'd0;
            control    <= 8'hFF;
            value      <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            slot_count <= slot_count_next;
            digit      <= digit_next;
            control    <= control_next;
            value      <= value_next;
            frame_done <= frame_done_next;
        end
    end

endmodule
